dmi_reg_bridge: RTL and testbench

//  Core-clock-side consumer of the DMI request/response stream leaving the JTAG DTM clock-domain crossing.

---
 rtl/dmi_reg_bridge_pkg.sv | 34 +++
 rtl/dmi_reg_bridge.sv | 146 ++++++++++++++
 tb/tb_dmi_reg_bridge.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_reg_bridge_pkg.sv
// Shared DMI types for the DTM-to-debug-module register bridge.
// Contents: DMI op/response encodings, request/response structs, timeout data
// word and a helper sizing the timeout counter.
package dmi_reg_bridge_pkg;

   typedef enum logic [1:0] {
      DTM_NOP   = 2'h0,
      DTM_READ  = 2'h1,
      DTM_WRITE = 2'h2
   } dtm_op_e;

   localparam logic [1:0] DTM_SUCCESS = 2'h0;
   localparam logic [1:0] DTM_ERR     = 2'h2;
   localparam logic [1:0] DTM_BUSY    = 2'h3;

   localparam logic [31:0] DmiTimeoutData = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [6:0]  addr;
      dtm_op_e     op;
      logic [31:0] data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   // A disabled timeout (0) still gets a 1-bit counter so no zero-width vector appears.
   function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/dmi_reg_bridge.sv
// Bridges one DMI request at a time onto a simple req/gnt/rvalid register bus
// and returns exactly one DMI response per request, with an access timeout.
// Ports: clk_i/rst_i (async active-high); dmi_req_* (request in, valid/ready);
// dmi_resp_* (response out, valid/ready); reg_* (register bus master side).
module dmi_reg_bridge
   import dmi_reg_bridge_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  dmi_req_t    dmi_req_i,
   input  logic        dmi_req_valid_i,
   output logic        dmi_req_ready_o,
   output dmi_resp_t   dmi_resp_o,
   output logic        dmi_resp_valid_o,
   input  logic        dmi_resp_ready_i,
   output logic        reg_req_o,
   output logic        reg_we_o,
   output logic [6:0]  reg_addr_o,
   output logic [31:0] reg_wdata_o,
   input  logic        reg_gnt_i,
   input  logic        reg_rvalid_i,
   input  logic [31:0] reg_rdata_i,
   input  logic        reg_err_i
);

   localparam int unsigned CntW = timeout_cnt_width(TimeoutCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
   localparam logic [CntW-1:0] CntMax  = '1;

   typedef enum logic [1:0] {
      Idle,
      Issue,
      WaitResp,
      Respond
   } state_e;

   state_e          state;
   logic [CntW-1:0] cnt;
   logic [CntW-1:0] cnt_inc;
   logic [1:0]      req_op;
   logic            req_fire;
   logic            timeout_hit;
   dmi_resp_t       completion;
   dmi_resp_t       abort_resp;

   always_comb begin
      req_op      = dmi_req_i.op;
      req_fire    = dmi_req_valid_i && dmi_req_ready_o;
      timeout_hit = (TimeoutCycles != 0) && (cnt == CntLast);
      // Saturate so a disabled timeout never wraps back into a false match.
      cnt_inc     = (cnt == CntMax) ? cnt : cnt + CntW'(1);
      // Writes return zero data; the slave's rdata is only meaningful for reads.
      completion.data = reg_we_o ? 32'h0 : reg_rdata_i;
      completion.resp = reg_err_i ? DTM_ERR : DTM_SUCCESS;
      abort_resp.data = DmiTimeoutData;
      abort_resp.resp = DTM_ERR;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= Idle;
         cnt              <= '0;
         dmi_req_ready_o  <= 1'b0;
         dmi_resp_o       <= '0;
         dmi_resp_valid_o <= 1'b0;
         reg_req_o        <= 1'b0;
         reg_we_o         <= 1'b0;
         reg_addr_o       <= '0;
         reg_wdata_o      <= '0;
      end else begin
         case (state)
            Idle: begin
               // Ready rises one cycle after reset and after every response handshake.
               dmi_req_ready_o <= !req_fire;
               if (req_fire) begin
                  reg_addr_o  <= dmi_req_i.addr;
                  reg_wdata_o <= dmi_req_i.data;
                  reg_we_o    <= (req_op == DTM_WRITE);
                  cnt         <= '0;
                  case (req_op)
                     DTM_READ, DTM_WRITE: begin
                        reg_req_o <= 1'b1;
                        state     <= Issue;
                     end
                     DTM_NOP: begin
                        dmi_resp_o       <= '{data: 32'h0, resp: DTM_SUCCESS};
                        dmi_resp_valid_o <= 1'b1;
                        state            <= Respond;
                     end
                     default: begin
                        dmi_resp_o       <= '{data: 32'h0, resp: DTM_ERR};
                        dmi_resp_valid_o <= 1'b1;
                        state            <= Respond;
                     end
                  endcase
               end
            end
            Issue: begin
               // A grant always wins over a coincident timeout.
               if (reg_gnt_i) begin
                  reg_req_o <= 1'b0;
                  cnt       <= '0;
                  if (reg_rvalid_i) begin
                     dmi_resp_o       <= completion;
                     dmi_resp_valid_o <= 1'b1;
                     state            <= Respond;
                  end else begin
                     state <= WaitResp;
                  end
               end else if (timeout_hit) begin
                  reg_req_o        <= 1'b0;
                  dmi_resp_o       <= abort_resp;
                  dmi_resp_valid_o <= 1'b1;
                  state            <= Respond;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WaitResp: begin
               if (reg_rvalid_i) begin
                  dmi_resp_o       <= completion;
                  dmi_resp_valid_o <= 1'b1;
                  state            <= Respond;
               end else if (timeout_hit) begin
                  dmi_resp_o       <= abort_resp;
                  dmi_resp_valid_o <= 1'b1;
                  state            <= Respond;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            Respond: begin
               if (dmi_resp_ready_i) begin
                  dmi_resp_valid_o <= 1'b0;
                  dmi_req_ready_o  <= 1'b1;
                  state            <= Idle;
               end
            end
            default: state <= Idle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmi_reg_bridge.sv
// Directed self-checking bench for dmi_reg_bridge with an 8-cycle timeout.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_dmi_reg_bridge;
   import dmi_reg_bridge_pkg::*;

   logic        clk_i;
   logic        rst_i;
   dmi_req_t    dmi_req_i;
   logic        dmi_req_valid_i;
   logic        dmi_req_ready_o;
   dmi_resp_t   dmi_resp_o;
   logic        dmi_resp_valid_o;
   logic        dmi_resp_ready_i;
   logic        reg_req_o;
   logic        reg_we_o;
   logic [6:0]  reg_addr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_gnt_i;
   logic        reg_rvalid_i;
   logic [31:0] reg_rdata_i;
   logic        reg_err_i;

   int errors = 0;
   int checks = 0;
   int req_cycles = 0;

   dmi_reg_bridge #(.TimeoutCycles(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dmi_req_i(dmi_req_i), .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
      .dmi_resp_o(dmi_resp_o), .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
      .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_gnt_i(reg_gnt_i), .reg_rvalid_i(reg_rvalid_i), .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) if (reg_req_o === 1'b1) req_cycles++;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Waits (bounded) for ready, presents one request, returns 1 unit after the accepting edge.
   task automatic send_req(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data);
      int n = 0;
      while (dmi_req_ready_o !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      checks++;
      if (dmi_req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: ready=%b after %0d cycles, required 1", dmi_req_ready_o, n);
      end
      dmi_req_i.addr  = addr;
      dmi_req_i.op    = dtm_op_e'(op);
      dmi_req_i.data  = data;
      dmi_req_valid_i = 1'b1;
      step();
      dmi_req_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      checks++;
      if ({dmi_req_ready_o, dmi_resp_valid_o, reg_req_o, reg_we_o} !== 4'b0 ||
          dmi_resp_o !== 34'h0 || reg_addr_o !== 7'h0 || reg_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b rv=%b req=%b we=%b resp=%h addr=%h wd=%h, required all 0",
                  dmi_req_ready_o, dmi_resp_valid_o, reg_req_o, reg_we_o, dmi_resp_o, reg_addr_o, reg_wdata_o);
      end
      rst_i = 1'b0;
      step();
      checks++;
      if (dmi_req_ready_o !== 1'b1 || dmi_resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ready=%b resp_valid=%b, required 1/0", dmi_req_ready_o, dmi_resp_valid_o);
      end
   endtask

   task automatic test_single_read();
      send_req(7'h11, 2'b01, 32'h0);
      checks++;
      if (reg_req_o !== 1'b1 || reg_we_o !== 1'b0 || reg_addr_o !== 7'h11 || dmi_req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL read_issue: req=%b we=%b addr=%h rdy=%b, required 1/0/11/0",
                  reg_req_o, reg_we_o, reg_addr_o, dmi_req_ready_o);
      end
      reg_gnt_i = 1'b1; reg_rvalid_i = 1'b1; reg_rdata_i = 32'h0000_0C82;
      step();
      reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'h0000_0C82, 2'b00} || reg_req_o !== 1'b0) begin
         errors++;
         $display("FAIL read_resp: valid=%b resp=%h req=%b, required 1/%h/0",
                  dmi_resp_valid_o, dmi_resp_o, reg_req_o, {32'h0000_0C82, 2'b00});
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL read_return_idle: resp_valid=%b ready=%b, required 0/1", dmi_resp_valid_o, dmi_req_ready_o);
      end
   endtask

   task automatic test_slow_write();
      send_req(7'h10, 2'b10, 32'h8000_0001);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         checks++;
         if (reg_req_o !== 1'b1 || reg_we_o !== 1'b1 || reg_addr_o !== 7'h10 || reg_wdata_o !== 32'h8000_0001) begin
            errors++;
            $display("FAIL write_hold[%0d]: req=%b we=%b addr=%h wd=%h, required 1/1/10/80000001",
                     i, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o);
         end
      end
      reg_gnt_i = 1'b1;
      step();
      reg_gnt_i = 1'b0;
      checks++;
      if (reg_req_o !== 1'b0 || dmi_resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL write_granted: req=%b resp_valid=%b, required 0/0", reg_req_o, dmi_resp_valid_o);
      end
      step();
      reg_rvalid_i = 1'b1; reg_rdata_i = 32'h1234_5678;
      step();
      reg_rvalid_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== 34'h0) begin
         errors++;
         $display("FAIL write_resp: valid=%b resp=%h, required 1/000000000", dmi_resp_valid_o, dmi_resp_o);
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
   endtask

   task automatic test_nop_reserved();
      req_cycles = 0;
      send_req(7'h20, 2'b00, 32'hFFFF_FFFF);
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'h0, 2'b00}) begin
         errors++;
         $display("FAIL nop_resp: valid=%b resp=%h, required 1/000000000", dmi_resp_valid_o, dmi_resp_o);
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
      send_req(7'h21, 2'b11, 32'h0000_1234);
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'h0, 2'b10}) begin
         errors++;
         $display("FAIL reserved_resp: valid=%b resp=%h, required 1/000000002", dmi_resp_valid_o, dmi_resp_o);
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
      checks++;
      if (req_cycles !== 0) begin
         errors++;
         $display("FAIL nop_no_reg_access: reg_req cycles=%0d, required 0", req_cycles);
      end
   endtask

   task automatic test_timeout();
      int cycles = 0;
      send_req(7'h05, 2'b01, 32'h0);
      while (reg_req_o === 1'b1 && cycles < 20) begin
         cycles++;
         step();
      end
      checks++;
      if (cycles != 8) begin
         errors++;
         $display("FAIL timeout_req_len: reg_req high %0d cycles, required 8", cycles);
      end
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'hDEAD_BEEF, 2'b10}) begin
         errors++;
         $display("FAIL timeout_resp: valid=%b resp=%h, required 1/%h", dmi_resp_valid_o, dmi_resp_o,
                  {32'hDEAD_BEEF, 2'b10});
      end
      reg_rvalid_i = 1'b1; reg_rdata_i = 32'h5555_5555;
      step();
      reg_rvalid_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'hDEAD_BEEF, 2'b10}) begin
         errors++;
         $display("FAIL timeout_late_rvalid: valid=%b resp=%h, required unchanged", dmi_resp_valid_o, dmi_resp_o);
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
      reg_rvalid_i = 1'b1;
      step();
      reg_rvalid_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1 || reg_req_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_rvalid_ignored: rv=%b rdy=%b req=%b, required 0/1/0",
                  dmi_resp_valid_o, dmi_req_ready_o, reg_req_o);
      end
   endtask

   task automatic test_back_to_back();
      send_req(7'h11, 2'b01, 32'h0);
      reg_gnt_i = 1'b1; reg_rvalid_i = 1'b1; reg_rdata_i = 32'hCAFE_0005;
      step();
      reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0;
      dmi_req_i.addr = 7'h12; dmi_req_i.op = DTM_READ; dmi_req_i.data = 32'h0;
      dmi_req_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'hCAFE_0005, 2'b00} || dmi_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL resp_hold[%0d]: valid=%b resp=%h rdy=%b, required 1/%h/0",
                     i, dmi_resp_valid_o, dmi_resp_o, dmi_req_ready_o, {32'hCAFE_0005, 2'b00});
         end
         step();
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1 || reg_req_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_same_cycle: rv=%b rdy=%b req=%b, required 0/1/0",
                  dmi_resp_valid_o, dmi_req_ready_o, reg_req_o);
      end
      step();
      dmi_req_valid_i = 1'b0;
      checks++;
      if (reg_req_o !== 1'b1 || reg_addr_o !== 7'h12) begin
         errors++;
         $display("FAIL b2b_second_issue: req=%b addr=%h, required 1/12", reg_req_o, reg_addr_o);
      end
      reg_gnt_i = 1'b1; reg_rvalid_i = 1'b1; reg_rdata_i = 32'h0000_0077; reg_err_i = 1'b1;
      step();
      reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_err_i = 1'b0;
      checks++;
      if (dmi_resp_o !== {32'h0000_0077, 2'b10}) begin
         errors++;
         $display("FAIL b2b_err_resp: resp=%h, required %h", dmi_resp_o, {32'h0000_0077, 2'b10});
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
   endtask

   task automatic test_reset_midflight();
      send_req(7'h04, 2'b01, 32'h0);
      reg_gnt_i = 1'b1;
      step();
      reg_gnt_i = 1'b0;
      #3;
      rst_i = 1'b1;
      #1;
      checks++;
      if ({dmi_req_ready_o, dmi_resp_valid_o, reg_req_o, reg_we_o} !== 4'b0 ||
          dmi_resp_o !== 34'h0 || reg_addr_o !== 7'h0 || reg_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: rdy=%b rv=%b req=%b we=%b resp=%h addr=%h wd=%h, required all 0",
                  dmi_req_ready_o, dmi_resp_valid_o, reg_req_o, reg_we_o, dmi_resp_o, reg_addr_o, reg_wdata_o);
      end
      step();
      rst_i = 1'b0;
      step();
      checks++;
      if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_dropped_txn: rv=%b rdy=%b, required 0/1", dmi_resp_valid_o, dmi_req_ready_o);
      end
      send_req(7'h13, 2'b01, 32'h0);
      reg_gnt_i = 1'b1; reg_rvalid_i = 1'b1; reg_rdata_i = 32'hA5A5_0001;
      step();
      reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0;
      checks++;
      if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== {32'hA5A5_0001, 2'b00}) begin
         errors++;
         $display("FAIL post_reset_read: valid=%b resp=%h, required 1/%h", dmi_resp_valid_o, dmi_resp_o,
                  {32'hA5A5_0001, 2'b00});
      end
      dmi_resp_ready_i = 1'b1;
      step();
      dmi_resp_ready_i = 1'b0;
   endtask

   initial begin
      rst_i            = 1'b1;
      dmi_req_i        = '0;
      dmi_req_valid_i  = 1'b0;
      dmi_resp_ready_i = 1'b0;
      reg_gnt_i        = 1'b0;
      reg_rvalid_i     = 1'b0;
      reg_rdata_i      = 32'h0;
      reg_err_i        = 1'b0;
      test_reset();
      test_single_read();
      test_slow_write();
      test_nop_reserved();
      test_timeout();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
